// File: rtl/spi_cmd_ctrl.sv
// SPI command sequencer: parses CS frames into register writes/reads on an 8x8 bank.
// Optional: define SPICTRL_AUTOINC_EN to advance the address after every data byte.
module spi_cmd_ctrl #(
  parameter int NREGS = 8,
  parameter int ERR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_active,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic [7:0]         tx_data,
  output logic               tx_load,
  output logic [8*NREGS-1:0] regs_out,
  output logic               led_status,
  output logic               led_error,
  output logic [ERR_W-1:0]   err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WRITE,
    S_READ,
    S_IGNORE
  } state_t;

  state_t           r_state;
  logic [2:0]       r_addr;
  logic [7:0]       r_regs [NREGS];
  logic [7:0]       r_txData;
  logic             r_txLoad;
  logic             r_ledStatus;
  logic [ERR_W-1:0] r_errCnt;

  logic [2:0]       w_nextAddr;
  logic             w_errSat;

`ifdef SPICTRL_AUTOINC_EN
  assign w_nextAddr = r_addr + 3'd1;
`else
  assign w_nextAddr = r_addr;
`endif

  assign w_errSat = &r_errCnt;

  // Frame loss beats everything: a byte arriving as CS drops is discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_txData    <= '0;
      r_txLoad    <= 1'b0;
      r_ledStatus <= 1'b0;
      r_errCnt    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_txLoad <= 1'b0;
      if (!frame_active) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CMD;
          end
          S_CMD: begin
            if (rx_valid) begin
              casez (rx_data)
                8'b01??_0???: begin
                  r_addr  <= rx_data[2:0];
                  r_state <= S_WRITE;
                end
                8'b10??_0???: begin
                  r_addr   <= rx_data[2:0];
                  r_txData <= r_regs[rx_data[2:0]];
                  r_txLoad <= 1'b1;
                  r_state  <= S_READ;
                end
                8'b11??_????: begin
                  r_txData <= {4'hA, r_errCnt};
                  r_txLoad <= 1'b1;
                  r_state  <= S_IGNORE;
                end
                8'b01??_1???, 8'b10??_1???: begin
                  if (!w_errSat) begin
                    r_errCnt <= r_errCnt + 1'b1;
                  end
                  r_state <= S_IGNORE;
                end
                default: begin
                  r_state <= S_IGNORE;
                end
              endcase
            end
          end
          S_WRITE: begin
            if (rx_valid) begin
              r_regs[r_addr] <= rx_data;
              r_ledStatus    <= ~r_ledStatus;
              r_addr         <= w_nextAddr;
            end
          end
          // The byte clocked in during READ is a dummy; only the reply matters.
          S_READ: begin
            if (rx_valid) begin
              r_addr   <= w_nextAddr;
              r_txData <= r_regs[w_nextAddr];
              r_txLoad <= 1'b1;
            end
          end
          S_IGNORE: begin
            r_state <= S_IGNORE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs_out[8*i +: 8] = r_regs[i];
    end
  end

  assign tx_data    = r_txData;
  assign tx_load    = r_txLoad;
  assign led_status = r_ledStatus;
  assign led_error  = (r_errCnt != '0);
  assign err_cnt    = r_errCnt;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl; expectations follow SPICTRL_AUTOINC_EN if defined.
module tb_spi_cmd_ctrl;

  logic        clk;
  logic        rst;
  logic        frame_active;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [7:0]  tx_data;
  logic        tx_load;
  logic [63:0] regs_out;
  logic        led_status;
  logic        led_error;
  logic [3:0]  err_cnt;

  int testsRun;
  int testsFailed;
  logic [7:0] expRegs [8];

  spi_cmd_ctrl #(.NREGS(8), .ERR_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_active (frame_active),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .tx_data      (tx_data),
    .tx_load      (tx_load),
    .regs_out     (regs_out),
    .led_status   (led_status),
    .led_error    (led_error),
    .err_cnt      (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a broken design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] packRegs();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = expRegs[i];
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one byte as a single-cycle rx_valid pulse; returns on the negedge after it was sampled.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic startFrame();
    @(negedge clk);
    frame_active = 1'b1;
    @(negedge clk);
  endtask

  task automatic endFrame();
    @(negedge clk);
    frame_active = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    testsRun     = 0;
    testsFailed  = 0;
    rst          = 1'b1;
    frame_active = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = 8'h00;
    for (int i = 0; i < 8; i++) expRegs[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    checkOutput("reset_regs", regs_out, 64'h0);
    checkOutput("reset_txdata", {56'h0, tx_data}, 64'h0);
    checkOutput("reset_txload", {63'h0, tx_load}, 64'h0);
    checkOutput("reset_leds", {62'h0, led_status, led_error}, 64'h0);
    checkOutput("reset_errcnt", {60'h0, err_cnt}, 64'h0);

    // Write 0x7E to reg3
    startFrame();
    applyStimulus(8'h43);
    applyStimulus(8'h7E);
    expRegs[3] = 8'h7E;
    checkOutput("write_reg3", regs_out, packRegs());
    checkOutput("write_led_status", {63'h0, led_status}, 64'h1);
    checkOutput("write_errcnt", {60'h0, err_cnt}, 64'h0);
    endFrame();

    // Read reg3 back, then one dummy byte
    startFrame();
    applyStimulus(8'h83);
    checkOutput("read_txload", {63'h0, tx_load}, 64'h1);
    checkOutput("read_txdata", {56'h0, tx_data}, 64'h7E);
    @(negedge clk);
    checkOutput("read_txload_pulse", {63'h0, tx_load}, 64'h0);
    applyStimulus(8'hFF);
    checkOutput("read2_txload", {63'h0, tx_load}, 64'h1);
`ifdef SPICTRL_AUTOINC_EN
    checkOutput("read2_txdata", {56'h0, tx_data}, 64'h00);
`else
    checkOutput("read2_txdata", {56'h0, tx_data}, 64'h7E);
`endif
    endFrame();
    checkOutput("idle_txload", {63'h0, tx_load}, 64'h0);

    // Wrap frame with back-to-back data bytes
    startFrame();
    applyStimulus(8'h47);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h11;
    @(negedge clk);
    rx_data  = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
`ifdef SPICTRL_AUTOINC_EN
    expRegs[7] = 8'h11;
    expRegs[0] = 8'h22;
`else
    expRegs[7] = 8'h22;
`endif
    checkOutput("wrap_regs", regs_out, packRegs());
    checkOutput("wrap_led_status", {63'h0, led_status}, 64'h1);
    endFrame();

    // Invalid write (addr bit 3 set)
    startFrame();
    applyStimulus(8'h4B);
    checkOutput("invalid_errcnt", {60'h0, err_cnt}, 64'h1);
    applyStimulus(8'h55);
    checkOutput("invalid_led_error", {63'h0, led_error}, 64'h1);
    checkOutput("invalid_regs", regs_out, packRegs());
    endFrame();

    startFrame();
    applyStimulus(8'hC0);
    checkOutput("status_txload", {63'h0, tx_load}, 64'h1);
    checkOutput("status_txdata", {56'h0, tx_data}, 64'hA1);
    endFrame();

    startFrame();
    applyStimulus(8'h88);
    checkOutput("invalid_read_errcnt", {60'h0, err_cnt}, 64'h2);
    checkOutput("invalid_read_txload", {63'h0, tx_load}, 64'h0);
    endFrame();

    // Frame drops in the same cycle as a data byte
    startFrame();
    applyStimulus(8'h41);
    @(negedge clk);
    rx_valid     = 1'b1;
    rx_data      = 8'h99;
    frame_active = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    checkOutput("abort_regs", regs_out, packRegs());
    @(negedge clk);
    startFrame();
    applyStimulus(8'h87);
    checkOutput("after_abort_txload", {63'h0, tx_load}, 64'h1);
    checkOutput("after_abort_txdata", {56'h0, tx_data}, {56'h0, expRegs[7]});
    applyStimulus(8'h33);
    checkOutput("after_abort_no_write", regs_out, packRegs());
    // Reset asserted mid-READ with CS still held
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_regs", regs_out, 64'h0);
    checkOutput("rst_txdata", {56'h0, tx_data}, 64'h0);
    checkOutput("rst_outs", {58'h0, tx_load, led_status, led_error, 1'b0, 2'b00}, 64'h0);
    checkOutput("rst_errcnt", {60'h0, err_cnt}, 64'h0);
    for (int i = 0; i < 8; i++) expRegs[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'hC0);
    checkOutput("post_rst_status_txload", {63'h0, tx_load}, 64'h1);
    checkOutput("post_rst_status_txdata", {56'h0, tx_data}, 64'hA0);
    endFrame();

    // Saturation of the error counter
    for (int k = 0; k < 16; k++) begin
      startFrame();
      applyStimulus(8'h48);
      endFrame();
    end
    checkOutput("errcnt_saturate", {60'h0, err_cnt}, 64'hF);
    checkOutput("sat_led_error", {63'h0, led_error}, 64'h1);
    checkOutput("sat_regs", regs_out, packRegs());

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
